unidad_fetch: RTL and testbench
===============================

# unidad_fetch

Sequential fetch unit for the single-cycle RISC-V core. It owns the program-counter register and drives `PC` into the existing external PC+4 adder (`Sumador`), consuming that adder's `Suma` output. It selects the next PC from `Suma`, a branch target, a JALR target or the trap vector. It fetches each instruction from instruction memory through a req/ready handshake and presents it to the core with a valid/stall handshake.

## Interface
- `RESET_VECTOR`, 32'h0000_0000, PC value loaded on reset
- `TRAP_VECTOR`, 32'h0000_0100, PC value loaded on `pc_src`=TRAP or a misaligned-target trap
- `clk`  in  1  single clock, all state on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `Suma`  in  32  PC+4 returned by `Sumador`
- `PC`  out  32  current program counter, feeds `Sumador` and instruction memory address
- `pc_src`  in  2  next-PC select: 00 Suma, 01 branch, 10 jalr, 11 trap
- `branch_target`  in  32  branch/JAL destination
- `jalr_target`  in  32  JALR destination, before bit-0 clearing
- `stall`  in  1  core not ready to consume `instr`
- `imem_req`  out  1  fetch request, address = `PC`
- `imem_ready`  in  1  `imem_rdata` valid this cycle
- `imem_rdata`  in  32  instruction word from memory
- `instr`  out  32  registered instruction
- `instr_valid`  out  1  `instr` valid for the core
- `misalign`  out  1  one-cycle pulse on a misaligned-target trap
- `bad_addr`  out  32  offending target, held until the next trap
- `instret`  out  32  retired-instruction counter

## Operation
- FSM states: INIT, FETCH, ISSUE.
- INIT: entered on reset. Outputs idle. Goes to FETCH on the first edge after reset deasserts.
- FETCH: `imem_req`=1. On an edge where `imem_ready`=1, capture `imem_rdata` into `instr` and go to ISSUE. Otherwise stay in FETCH with `PC` held.
- ISSUE: `instr_valid`=1 and `imem_req`=0.
  - `stall`=1: hold `PC`, `instr` and `instret`.
  - `stall`=0: at the edge, `PC`<=next, `instret`+=1, go to FETCH.
- Next PC:
  - Suma: taken as-is; 32'hFFFF_FFFC wraps to 0.
  - branch: `branch_target`.
  - jalr: `jalr_target` with bit 0 cleared.
  - trap: `TRAP_VECTOR`.
- Alignment check applies to the branch and jalr targets only. A target with [1:0]≠0 is handled per Configuration.
- `instret` wraps from 32'hFFFF_FFFF to 0. A trap instruction also counts as retired.
- Reset values: `PC`=`RESET_VECTOR`, `instr`=32'h0000_0013 (NOP), `instr_valid`=0, `imem_req`=0, `misalign`=0, `bad_addr`=0, `instret`=0, state INIT.

## Timing
- Minimum two cycles per instruction: FETCH, then ISSUE.
- `imem_ready` may be high in the same cycle as `imem_req` (combinational memory).
- `Suma` is combinational from `PC`; it is sampled only in ISSUE.
- `PC` changes only on the ISSUE→FETCH edge. `instr_valid` falls on that same edge.
- `misalign` is high for exactly the first FETCH cycle after a trapping ISSUE.
- `pc_src`, both targets and `stall` are sampled only in ISSUE. They are ignored in INIT and FETCH.
- Reset during any state, including FETCH waiting on `imem_ready`:
  - all outputs go to their reset values immediately (asynchronously);
  - a late `imem_ready` is ignored.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - a misaligned branch/jalr target loads `TRAP_VECTOR`;
  - pulses `misalign`;
  - captures the target in `bad_addr`.
- Not defined:
  - target bits [1:0] are forced to 0 and no trap occurs;
  - `misalign` is tied to 0 and `bad_addr` to 0.

## Structure
- Shared package `riscv_pkg` holds:
  - `pc_src_t` enum: PC_PLUS4, PC_BRANCH, PC_JALR, PC_TRAP;
  - `fetch_state_t` enum: INIT, FETCH, ISSUE;
  - NOP constant 32'h0000_0013.
- No sub-module. `Sumador` stays external and is connected at the top level.

## Test plan
- Reset: hold `reset` 3 cycles → `PC`=0, `imem_req`=0, `instr_valid`=0. One INIT cycle after release, then `imem_req`=1 with `PC`=0.
- Sequential: `imem_ready`=1 constant, `pc_src`=00, `Sumador` connected → `PC` = 0, 4, 8, 12, changing every 2 cycles; `instret` counts 0 to 3.
- Branch: in ISSUE at `PC`=8, `pc_src`=01, `branch_target`=32'h40 → next FETCH has `PC`=32'h40 and `instret` increments.
- JALR misaligned: `pc_src`=10, `jalr_target`=32'h23.
  - With the macro: `PC`=32'h100, `misalign` pulses 1 cycle, `bad_addr`=32'h22.
  - Without the macro: `PC`=32'h20.
- Stalls:
  - `stall`=1 for 3 ISSUE cycles → `PC`, `instr`, `instret` unchanged; `instr_valid` stays 1.
  - `imem_ready` low for 4 FETCH cycles → `imem_req` stays 1 and `PC` is held.
- Reset mid-fetch: assert `reset` in FETCH with `imem_ready`=0 → `imem_req` drops and `PC`=`RESET_VECTOR` before the next edge. A subsequent `imem_ready` pulse during reset has no effect.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch stage of the single-cycle RISC-V core.
//   pc_src_t      : next-PC select encoding driven by the core
//   fetch_state_t : fetch FSM state encoding
//   NOP, RESET_VECTOR, TRAP_VECTOR : architectural constants
//   clear_low2 / is_misaligned     : word-alignment helpers for jump targets
package riscv_pkg;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10,
    PC_TRAP   = 2'b11
  } pc_src_t;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP          = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0100;

  // Force a target onto a word boundary.
  function automatic logic [31:0] clear_low2(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/unidad_fetch_if.sv
// Handshake bundle between the fetch unit, instruction memory and the core.
//   imem_req    : fetch request (address is the fetch unit's PC output)
//   imem_ready  : imem_rdata valid this cycle
//   imem_rdata  : instruction word returned by memory
//   instr       : registered instruction presented to the core
//   instr_valid : instr valid for the core
//   stall       : core not ready to consume instr
// Modports: master = fetch unit, slave = memory/core side.
interface unidad_fetch_if;

  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;

  modport master (
    output imem_req,
    input  imem_ready,
    input  imem_rdata,
    output instr,
    output instr_valid,
    input  stall
  );

  modport slave (
    input  imem_req,
    output imem_ready,
    output imem_rdata,
    input  instr,
    input  instr_valid,
    output stall
  );

endinterface

// File: rtl/unidad_fetch.sv
// Sequential fetch unit: owns the PC, fetches one instruction per FETCH/ISSUE pair and
// selects the next PC from the external PC+4 adder, a branch target, a JALR target or
// the trap vector.
//
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   Suma          : PC+4 from the external Sumador adder (combinational from PC)
//   PC            : current program counter (adder input and imem address)
//   pc_src        : next-PC select (00 Suma, 01 branch, 10 jalr, 11 trap)
//   branch_target : branch/JAL destination
//   jalr_target   : JALR destination before bit-0 clearing
//   bus           : imem req/ready/rdata and core instr/instr_valid/stall handshake
//   misalign      : one-cycle pulse after a misaligned-target trap
//   bad_addr      : offending target of the last misaligned trap
//   instret       : retired-instruction counter (wraps)
//
// Build option: MISALIGN_TRAP_EN makes a misaligned branch/jalr target trap; when
// undefined the low two target bits are dropped and misalign/bad_addr read 0.
module unidad_fetch
  import riscv_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic [31:0]    Suma,
  output logic [31:0]    PC,
  input  logic [1:0]     pc_src,
  input  logic [31:0]    branch_target,
  input  logic [31:0]    jalr_target,
  unidad_fetch_if.master bus,
  output logic           misalign,
  output logic [31:0]    bad_addr,
  output logic [31:0]    instret
);

  localparam logic [1:0] StInit  = INIT;
  localparam logic [1:0] StFetch = FETCH;
  localparam logic [1:0] StIssue = ISSUE;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;

  pc_src_t     sel;
  logic        retire;
  logic [31:0] target;
  logic        target_used;
  logic [31:0] next_pc;

  assign sel    = pc_src_t'(pc_src);
  assign retire = (state_q == StIssue) && !bus.stall;

  // Candidate jump target; only meaningful for branch and jalr selects.
  always_comb begin
    target      = '0;
    target_used = 1'b0;
    case (sel)
      PC_BRANCH: begin
        target      = branch_target;
        target_used = 1'b1;
      end
      PC_JALR: begin
        target      = jalr_target & ~32'h1;
        target_used = 1'b1;
      end
      default: begin
        target      = '0;
        target_used = 1'b0;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic        target_bad;
  logic        misalign_q, misalign_d;
  logic [31:0] bad_addr_q, bad_addr_d;

  assign target_bad = target_used && is_misaligned(target);

  always_comb begin
    if (sel == PC_TRAP || target_bad) begin
      next_pc = TRAP_VECTOR;
    end else if (target_used) begin
      next_pc = target;
    end else begin
      next_pc = Suma;
    end
  end

  // The pulse is registered so it lands on the first FETCH cycle after the trap.
  always_comb begin
    misalign_d = retire && target_bad;
    bad_addr_d = bad_addr_q;
    if (retire && target_bad) begin
      bad_addr_d = target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_q <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      misalign_q <= misalign_d;
      bad_addr_q <= bad_addr_d;
    end
  end

  assign misalign = misalign_q;
  assign bad_addr = bad_addr_q;
`else
  always_comb begin
    if (sel == PC_TRAP) begin
      next_pc = TRAP_VECTOR;
    end else if (target_used) begin
      next_pc = clear_low2(target);
    end else begin
      next_pc = Suma;
    end
  end

  assign misalign = 1'b0;
  assign bad_addr = '0;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    case (state_q)
      StInit: begin
        state_d = StFetch;
      end
      StFetch: begin
        if (bus.imem_ready) begin
          instr_d = bus.imem_rdata;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (!bus.stall) begin
          pc_d      = next_pc;
          instret_d = instret_q + 32'd1;
          state_d   = StFetch;
        end
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StInit;
      pc_q      <= RESET_VECTOR;
      instr_q   <= NOP;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
    end
  end

  // Handshake outputs decode straight from state so reset clears them immediately.
  assign bus.imem_req    = (state_q == StFetch);
  assign bus.instr_valid = (state_q == StIssue);
  assign bus.instr       = instr_q;
  assign PC              = pc_q;
  assign instret         = instret_q;

endmodule

// File: tb/tb_unidad_fetch.sv
// Self-checking bench for unidad_fetch: directed scenarios followed by randomized
// instruction streams checked against a transaction-level reference model.
module tb_unidad_fetch;

  logic        clk;
  logic        reset;
  logic [31:0] suma;
  logic [31:0] pc;
  logic [1:0]  pc_src;
  logic [31:0] branch_target;
  logic [31:0] jalr_target;
  logic        misalign;
  logic [31:0] bad_addr;
  logic [31:0] instret;

  unidad_fetch_if bus_if ();

  unidad_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .Suma         (suma),
    .PC           (pc),
    .pc_src       (pc_src),
    .branch_target(branch_target),
    .jalr_target  (jalr_target),
    .bus          (bus_if),
    .misalign     (misalign),
    .bad_addr     (bad_addr),
    .instret      (instret)
  );

  // External Sumador.
  assign suma = pc + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural state after each retired instruction.
  logic [31:0] m_pc;
  logic [31:0] m_instret;
  logic [31:0] m_instr;
  logic [31:0] m_bad;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = 32'h0;
    m_instret = 32'h0;
    m_instr   = 32'h0000_0013;
    m_bad     = 32'h0;
  endtask

  // Next PC from the selection rules; exp_mis reports a misaligned-target trap.
  task automatic model_next(input logic [1:0] src, input logic [31:0] bt,
                            input logic [31:0] jt, output logic [31:0] npc,
                            output logic exp_mis);
    logic [31:0] t;
    exp_mis = 1'b0;
    npc     = 32'h0;
    case (src)
      2'd0: npc = m_pc + 32'd4;
      2'd3: npc = 32'h0000_0100;
      default: begin
        t = (src == 2'd1) ? bt : (jt - (jt % 2));
        if (t % 4 != 0) begin
`ifdef MISALIGN_TRAP_EN
          npc     = 32'h0000_0100;
          exp_mis = 1'b1;
          m_bad   = t;
`else
          npc = t - (t % 4);
`endif
        end else begin
          npc = t;
        end
      end
    endcase
  endtask

  // Entered at a negedge with the DUT in FETCH; returns at the negedge in ISSUE.
  task automatic do_fetch(input int delay);
    logic [31:0] word;
    word = $urandom;
    bus_if.imem_ready = 1'b0;
    check_eq("fetch_req", bus_if.imem_req, 1'b1);
    check_eq("fetch_pc", pc, m_pc);
    for (int i = 0; i < delay; i++) begin
      bus_if.imem_rdata = $urandom;
      bus_if.stall      = 1'($urandom);
      pc_src            = 2'($urandom);
      @(negedge clk);
      check_eq("wait_req", bus_if.imem_req, 1'b1);
      check_eq("wait_pc", pc, m_pc);
      check_eq("wait_valid", bus_if.instr_valid, 1'b0);
      check_eq("wait_misalign", misalign, 1'b0);
    end
    bus_if.imem_ready = 1'b1;
    bus_if.imem_rdata = word;
    @(negedge clk);
    bus_if.imem_ready = 1'b0;
    m_instr = word;
    check_eq("issue_valid", bus_if.instr_valid, 1'b1);
    check_eq("issue_req", bus_if.imem_req, 1'b0);
    check_eq("issue_instr", bus_if.instr, m_instr);
    check_eq("issue_pc", pc, m_pc);
    check_eq("issue_misalign", misalign, 1'b0);
  endtask

  // Entered at a negedge in ISSUE; returns at the negedge of the next FETCH.
  task automatic do_issue(input int stalls, input logic [1:0] src, input logic [31:0] bt,
                          input logic [31:0] jt);
    logic [31:0] npc;
    logic        exp_mis;
    for (int i = 0; i < stalls; i++) begin
      bus_if.stall  = 1'b1;
      pc_src        = 2'($urandom);
      branch_target = $urandom;
      jalr_target   = $urandom;
      @(negedge clk);
      check_eq("stall_valid", bus_if.instr_valid, 1'b1);
      check_eq("stall_pc", pc, m_pc);
      check_eq("stall_instr", bus_if.instr, m_instr);
      check_eq("stall_instret", instret, m_instret);
    end
    bus_if.stall  = 1'b0;
    pc_src        = src;
    branch_target = bt;
    jalr_target   = jt;
    model_next(src, bt, jt, npc, exp_mis);
    @(negedge clk);
    m_pc      = npc;
    m_instret = m_instret + 32'd1;
    check_eq("next_pc", pc, m_pc);
    check_eq("next_instret", instret, m_instret);
    check_eq("next_valid", bus_if.instr_valid, 1'b0);
    check_eq("next_req", bus_if.imem_req, 1'b1);
    check_eq("next_instr", bus_if.instr, m_instr);
    check_eq("next_misalign", misalign, exp_mis);
    check_eq("next_bad_addr", bad_addr, m_bad);
    // Core-side inputs are ignored outside ISSUE.
    bus_if.stall  = 1'($urandom);
    pc_src        = 2'($urandom);
    branch_target = $urandom;
    jalr_target   = $urandom;
  endtask

  initial begin
    logic [31:0] bt;
    logic [31:0] jt;
    reset             = 1'b1;
    bus_if.imem_ready = 1'b0;
    bus_if.imem_rdata = 32'h0;
    bus_if.stall      = 1'b0;
    pc_src            = 2'b00;
    branch_target     = 32'h0;
    jalr_target       = 32'h0;
    model_reset();

    // Reset held for 3 cycles.
    repeat (3) @(negedge clk);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_req", bus_if.imem_req, 1'b0);
    check_eq("rst_valid", bus_if.instr_valid, 1'b0);
    check_eq("rst_instr", bus_if.instr, 32'h0000_0013);
    check_eq("rst_instret", instret, 32'h0);
    check_eq("rst_misalign", misalign, 1'b0);
    check_eq("rst_bad_addr", bad_addr, 32'h0);
    reset = 1'b0;
    #1;
    check_eq("init_req", bus_if.imem_req, 1'b0);
    @(negedge clk);
    check_eq("first_fetch_req", bus_if.imem_req, 1'b1);
    check_eq("first_fetch_pc", pc, 32'h0);

    // Sequential 0 -> 4 -> 8, branch at 8 to 0x40.
    do_fetch(0); do_issue(0, 2'b00, 32'h0, 32'h0);
    do_fetch(0); do_issue(0, 2'b00, 32'h0, 32'h0);
    check_eq("seq_pc8", pc, 32'h8);
    check_eq("seq_instret2", instret, 32'd2);
    do_fetch(0); do_issue(0, 2'b01, 32'h40, 32'h0);
    check_eq("branch_pc", pc, 32'h40);
    check_eq("branch_instret", instret, 32'd3);

    // Misaligned JALR.
    do_fetch(0); do_issue(0, 2'b10, 32'h0, 32'h23);
`ifdef MISALIGN_TRAP_EN
    check_eq("jalr_trap_pc", pc, 32'h100);
    check_eq("jalr_bad_addr", bad_addr, 32'h22);
`else
    check_eq("jalr_pc", pc, 32'h20);
    check_eq("jalr_bad_addr", bad_addr, 32'h0);
`endif

    // Stall 3 ISSUE cycles, then memory wait 4 FETCH cycles.
    do_fetch(0); do_issue(3, 2'b00, 32'h0, 32'h0);
    do_fetch(4); do_issue(0, 2'b01, 32'hFFFF_FFFC, 32'h0);
    // Suma wraps from 0xFFFFFFFC to 0.
    do_fetch(1); do_issue(0, 2'b00, 32'h0, 32'h0);
    check_eq("wrap_pc", pc, 32'h0);
    do_fetch(0); do_issue(1, 2'b11, 32'h0, 32'h0);
    check_eq("trap_pc", pc, 32'h100);

    // Randomized instruction stream.
    for (int n = 0; n < 200; n++) begin
      bt = $urandom;
      jt = $urandom;
      if ($urandom_range(0, 1) == 1) bt = bt & ~32'h3;
      if ($urandom_range(0, 1) == 1) jt = jt & ~32'h2;
      do_fetch($urandom_range(0, 3));
      do_issue($urandom_range(0, 3), 2'($urandom_range(0, 3)), bt, jt);
    end

    // Reset while FETCH waits on memory.
    bus_if.imem_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_eq("mid_rst_req", bus_if.imem_req, 1'b0);
    check_eq("mid_rst_pc", pc, 32'h0);
    check_eq("mid_rst_instret", instret, 32'h0);
    check_eq("mid_rst_misalign", misalign, 1'b0);
    check_eq("mid_rst_bad_addr", bad_addr, 32'h0);
    bus_if.imem_ready = 1'b1;
    bus_if.imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    check_eq("late_ready_valid", bus_if.instr_valid, 1'b0);
    check_eq("late_ready_instr", bus_if.instr, 32'h0000_0013);
    check_eq("late_ready_req", bus_if.imem_req, 1'b0);
    @(negedge clk);
    bus_if.imem_ready = 1'b0;
    reset = 1'b0;
    #1;
    check_eq("post_rst_init", bus_if.imem_req, 1'b0);
    @(negedge clk);
    do_fetch(0); do_issue(0, 2'b00, 32'h0, 32'h0);
    check_eq("post_rst_pc", pc, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
